// File: rtl/bus_rr_arbiter_if.sv
// Request, grant and transfer-handshake bundle shared by the bus masters and the round-robin arbiter.
// The arbiter connects through the master modport; the requesting side connects through slave.
interface bus_rr_arbiter_if;
  logic [7:0] DMA;
  logic [7:0] grant;
  logic       BUS_req;
  logic       BUS_ready;
  logic       bus_busy;
  logic [2:0] owner;
  logic       bus_err;
  logic [2:0] err_master;

  modport master (
    input  DMA, BUS_req, BUS_ready,
    output grant, bus_busy, owner, bus_err, err_master
  );

  modport slave (
    output DMA, BUS_req, BUS_ready,
    input  grant, bus_busy, owner, bus_err, err_master
  );
endinterface

// File: rtl/bus_rr_arbiter.sv
// 8-master round-robin bus arbiter: grant 1 cycle after request from idle, one idle turnaround cycle per release.
// Backpressure: the owner keeps the bus until BUS_req drops; slave timeout abort is enabled by BUS_TIMEOUT_EN.
module bus_rr_arbiter #(
  parameter int HOLD_MAX = 16,
  parameter int TIMEOUT  = 1024
) (
  input  logic             clk,
  input  logic             clr_in,
  bus_rr_arbiter_if.master bus
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_t;

  localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);

  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold
    $error("bus_rr_arbiter: HOLD_MAX must be within 1..255");
  end
  if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("bus_rr_arbiter: TIMEOUT must be within 2..65535");
  end

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_grant;
  logic [7:0] w_grant_nxt;
  logic [2:0] r_owner;
  logic [2:0] w_owner_nxt;
  logic [2:0] r_rr_ptr;
  logic [2:0] w_rr_ptr_nxt;
  logic [7:0] r_xfer_cnt;
  logic [7:0] w_xfer_cnt_nxt;
  logic       r_bus_busy;
  logic       w_bus_busy_nxt;

  logic [2:0] w_winner;
  logic [2:0] w_idx;
  logic       w_any_req;
  logic       w_xfer;
  logic       w_owner_req;
  logic       w_others;
  logic       w_quota;
  logic       w_release;
  logic       w_abort;

  // Search starts one past the last winner, so the previous owner is considered last.
  always_comb begin
    w_winner  = r_rr_ptr;
    w_any_req = 1'b0;
    w_idx     = r_rr_ptr;
    for (int k = 1; k <= 8; k++) begin
      w_idx = r_rr_ptr + 3'(k);
      if (!w_any_req && bus.DMA[w_idx]) begin
        w_winner  = w_idx;
        w_any_req = 1'b1;
      end
    end
  end

  assign w_xfer      = bus.BUS_req & bus.BUS_ready;
  assign w_owner_req = bus.DMA[r_owner];
  assign w_others    = |(bus.DMA & ~r_grant);
  assign w_quota     = (r_xfer_cnt == HOLD_LIM);

  // Release waits for BUS_req low, so a transfer in flight always finishes first.
  assign w_release = (r_state == ST_OWN) && !bus.BUS_req &&
                     (!w_owner_req || (w_quota && w_others));

`ifdef BUS_TIMEOUT_EN
  localparam logic [15:0] WAIT_LIM = 16'(TIMEOUT - 1);

  logic [15:0] r_wait_cnt;
  logic [15:0] w_wait_cnt_nxt;
  logic        r_bus_err;
  logic [2:0]  r_err_master;
  logic        w_stall;

  assign w_stall = bus.BUS_req & ~bus.BUS_ready;
  assign w_abort = (r_state == ST_OWN) && w_stall && (r_wait_cnt == WAIT_LIM);

  always_comb begin
    w_wait_cnt_nxt = 16'd0;
    if ((r_state == ST_OWN) && w_stall && !w_abort) begin
      w_wait_cnt_nxt = r_wait_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge clr_in) begin
    if (!clr_in) begin
      r_wait_cnt   <= 16'd0;
      r_bus_err    <= 1'b0;
      r_err_master <= 3'd0;
    end else begin
      r_wait_cnt <= w_wait_cnt_nxt;
      r_bus_err  <= w_abort;
      if (w_abort) begin
        r_err_master <= r_owner;
      end
    end
  end

  assign bus.bus_err    = r_bus_err;
  assign bus.err_master = r_err_master;
`else
  assign w_abort        = 1'b0;
  assign bus.bus_err    = 1'b0;
  assign bus.err_master = 3'd0;
`endif

  always_ff @(posedge clk or negedge clr_in) begin
    if (!clr_in) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_any_req) w_state_nxt = ST_OWN;
      ST_OWN:  if (w_release || w_abort) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_grant_nxt    = r_grant;
    w_owner_nxt    = r_owner;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_xfer_cnt_nxt = r_xfer_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          w_grant_nxt    = 8'b1 << w_winner;
          w_owner_nxt    = w_winner;
          w_rr_ptr_nxt   = w_winner;
          w_xfer_cnt_nxt = 8'd0;
        end
      end
      ST_OWN: begin
        if (w_abort) begin
          w_grant_nxt  = 8'd0;
          w_rr_ptr_nxt = r_owner;
        end else if (w_release) begin
          w_grant_nxt = 8'd0;
        end else if (w_xfer && !w_quota) begin
          w_xfer_cnt_nxt = r_xfer_cnt + 8'd1;
        end
      end
      default: w_grant_nxt = 8'd0;
    endcase
    w_bus_busy_nxt = |w_grant_nxt;
  end

  always_ff @(posedge clk or negedge clr_in) begin
    if (!clr_in) begin
      r_grant    <= 8'd0;
      r_owner    <= 3'd0;
      r_rr_ptr   <= 3'd7;
      r_xfer_cnt <= 8'd0;
      r_bus_busy <= 1'b0;
    end else begin
      r_grant    <= w_grant_nxt;
      r_owner    <= w_owner_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_xfer_cnt <= w_xfer_cnt_nxt;
      r_bus_busy <= w_bus_busy_nxt;
    end
  end

  assign bus.grant    = r_grant;
  assign bus.bus_busy = r_bus_busy;
  assign bus.owner    = r_owner;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Bench for bus_rr_arbiter: directed scenarios plus a randomized run against a tenure-level reference model.
// Timeout scenarios are compiled in with BUS_TIMEOUT_EN; otherwise the hung-slave scenario runs.
module tb_bus_rr_arbiter;
  localparam int HOLD = 4;
  localparam int TOUT = 8;

  logic clk = 1'b0;
  logic clr_in;
  int   n_cmp  = 0;
  int   n_fail = 0;

  bus_rr_arbiter_if bif ();

  bus_rr_arbiter #(.HOLD_MAX(HOLD), .TIMEOUT(TOUT)) dut (
    .clk    (clk),
    .clr_in (clr_in),
    .bus    (bif)
  );

  always #5 clk = ~clk;

  // Reference model: who owns the bus, transfers done and stall run in this tenure.
  int m_owner;
  int m_last;
  int m_ptr;
  int m_done;
  int m_stall_run;
  bit m_err;
  int m_err_master;

  task automatic model_reset();
    m_owner      = -1;
    m_last       = 0;
    m_ptr        = 7;
    m_done       = 0;
    m_stall_run  = 0;
    m_err        = 1'b0;
    m_err_master = 0;
  endtask

  task automatic model_step(input logic [7:0] dma, input logic req, input logic rdy);
    bit others;
    bit drop;
    if (!clr_in) begin
      model_reset();
      return;
    end
    m_err = 1'b0;
    if (m_owner < 0) begin
      bit found;
      found = 1'b0;
      for (int k = 1; k <= 8; k++) begin
        int c;
        c = (m_ptr + k) % 8;
        if (!found && dma[c]) begin
          found       = 1'b1;
          m_owner     = c;
          m_last      = c;
          m_ptr       = c;
          m_done      = 0;
          m_stall_run = 0;
        end
      end
    end else begin
      others = 1'b0;
      for (int i = 0; i < 8; i++) if (i != m_owner && dma[i]) others = 1'b1;
      drop = !req && (!dma[m_owner] || (m_done >= HOLD && others));
`ifdef BUS_TIMEOUT_EN
      if (req && !rdy && (m_stall_run + 1 == TOUT)) begin
        drop         = 1'b1;
        m_err        = 1'b1;
        m_err_master = m_owner;
        m_ptr        = m_owner;
      end
`endif
      if (req && !rdy) m_stall_run++;
      else m_stall_run = 0;
      if (req && rdy) m_done++;
      if (drop) m_owner = -1;
    end
  endtask

  function automatic logic [7:0] exp_grant();
    return (m_owner < 0) ? 8'h00 : (8'h01 << m_owner);
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_step(bif.DMA, bif.BUS_req, bif.BUS_ready);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    clr_in        = 1'b0;
    bif.DMA       = 8'h00;
    bif.BUS_req   = 1'b0;
    bif.BUS_ready = 1'b0;
    model_reset();
    cycle();
    cycle();
    clr_in = 1'b1;
  endtask

  task automatic test_reset();
    clr_in        = 1'b0;
    bif.DMA       = 8'hFF;
    bif.BUS_req   = 1'b1;
    bif.BUS_ready = 1'b1;
    model_reset();
    cycle();
    cycle();
    n_cmp++;
    if ({bif.grant, bif.bus_busy, bif.owner, bif.bus_err, bif.err_master} !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_outputs: got grant=%h busy=%b owner=%0d err=%b errm=%0d, want all zero",
               bif.grant, bif.bus_busy, bif.owner, bif.bus_err, bif.err_master);
    end
    apply_reset();
  endtask

  task automatic test_single_grant();
    apply_reset();
    bif.DMA = 8'h02;
    cycle();
    n_cmp++;
    if ({bif.grant, bif.bus_busy, bif.owner} !== {8'h02, 1'b1, 3'd1}) begin
      n_fail++;
      $display("FAIL single_grant: got grant=%h busy=%b owner=%0d, want 02/1/1", bif.grant, bif.bus_busy, bif.owner);
    end
    bif.DMA = 8'h00;
    cycle();
    n_cmp++;
    if ({bif.grant, bif.bus_busy, bif.owner} !== {8'h00, 1'b0, 3'd1}) begin
      n_fail++;
      $display("FAIL single_release: got grant=%h busy=%b owner=%0d, want 00/0/1", bif.grant, bif.bus_busy, bif.owner);
    end
    cycle();
    n_cmp++;
    if (bif.grant !== 8'h00) begin
      n_fail++;
      $display("FAIL single_stay_idle: got grant=%h, want 00", bif.grant);
    end
  endtask

  task automatic test_rotation();
    apply_reset();
    bif.DMA = 8'h03;
    cycle();
    n_cmp++;
    if (bif.grant !== 8'h01) begin
      n_fail++;
      $display("FAIL rot_first: got grant=%h, want 01", bif.grant);
    end
    bif.DMA = 8'h02;
    cycle();
    n_cmp++;
    if (bif.grant !== 8'h00) begin
      n_fail++;
      $display("FAIL rot_turnaround: got grant=%h, want 00", bif.grant);
    end
    cycle();
    n_cmp++;
    if ({bif.grant, bif.owner} !== {8'h02, 3'd1}) begin
      n_fail++;
      $display("FAIL rot_second: got grant=%h owner=%0d, want 02/1", bif.grant, bif.owner);
    end
    bif.DMA = 8'h01;
    cycle();
    cycle();
    n_cmp++;
    if ({bif.grant, bif.owner} !== {8'h01, 3'd0}) begin
      n_fail++;
      $display("FAIL rot_wrap: got grant=%h owner=%0d, want 01/0", bif.grant, bif.owner);
    end
    bif.DMA = 8'h00;
    cycle();
    cycle();
  endtask

  task automatic test_quota();
    apply_reset();
    bif.DMA = 8'h81;
    cycle();
    bif.BUS_req   = 1'b1;
    bif.BUS_ready = 1'b1;
    repeat (3) cycle();
    bif.BUS_req   = 1'b0;
    bif.BUS_ready = 1'b0;
    cycle();
    n_cmp++;
    if (bif.grant !== 8'h01) begin
      n_fail++;
      $display("FAIL quota_below_limit: got grant=%h, want 01", bif.grant);
    end
    bif.BUS_req   = 1'b1;
    bif.BUS_ready = 1'b1;
    cycle();
    bif.BUS_req   = 1'b0;
    bif.BUS_ready = 1'b0;
    n_cmp++;
    if (bif.grant !== 8'h01) begin
      n_fail++;
      $display("FAIL quota_hit_held: got grant=%h, want 01", bif.grant);
    end
    cycle();
    n_cmp++;
    if (bif.grant !== 8'h00) begin
      n_fail++;
      $display("FAIL quota_preempt: got grant=%h, want 00", bif.grant);
    end
    cycle();
    n_cmp++;
    if ({bif.grant, bif.owner} !== {8'h80, 3'd7}) begin
      n_fail++;
      $display("FAIL quota_next_owner: got grant=%h owner=%0d, want 80/7", bif.grant, bif.owner);
    end
    apply_reset();
    bif.DMA = 8'h01;
    cycle();
    bif.BUS_req   = 1'b1;
    bif.BUS_ready = 1'b1;
    repeat (6) cycle();
    bif.BUS_req   = 1'b0;
    bif.BUS_ready = 1'b0;
    cycle();
    cycle();
    n_cmp++;
    if (bif.grant !== 8'h01) begin
      n_fail++;
      $display("FAIL quota_sole_keeps: got grant=%h, want 01", bif.grant);
    end
    bif.DMA = 8'h00;
    cycle();
  endtask

`ifdef BUS_TIMEOUT_EN
  task automatic test_timeout();
    int bad;
    apply_reset();
    bif.DMA = 8'h0C;
    cycle();
    bif.BUS_req   = 1'b1;
    bif.BUS_ready = 1'b0;
    bad = 0;
    repeat (TOUT - 1) begin
      cycle();
      if (bif.grant !== 8'h04 || bif.bus_err !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL to_before_limit: got %0d bad cycles, want 0", bad);
    end
    cycle();
    n_cmp++;
    if ({bif.grant, bif.bus_err, bif.err_master} !== {8'h00, 1'b1, 3'd2}) begin
      n_fail++;
      $display("FAIL to_abort: got grant=%h err=%b errm=%0d, want 00/1/2", bif.grant, bif.bus_err, bif.err_master);
    end
    bif.BUS_req = 1'b0;
    cycle();
    n_cmp++;
    if ({bif.grant, bif.bus_err, bif.err_master} !== {8'h08, 1'b0, 3'd2}) begin
      n_fail++;
      $display("FAIL to_next_grant: got grant=%h err=%b errm=%0d, want 08/0/2", bif.grant, bif.bus_err, bif.err_master);
    end
    bif.DMA = 8'h00;
    cycle();
    cycle();
  endtask

  task automatic test_timeout_ready();
    apply_reset();
    bif.DMA = 8'h04;
    cycle();
    bif.BUS_req   = 1'b1;
    bif.BUS_ready = 1'b0;
    repeat (TOUT - 1) cycle();
    bif.BUS_ready = 1'b1;
    cycle();
    n_cmp++;
    if ({bif.grant, bif.bus_err} !== {8'h04, 1'b0}) begin
      n_fail++;
      $display("FAIL to_ready_wins: got grant=%h err=%b, want 04/0", bif.grant, bif.bus_err);
    end
    bif.BUS_ready = 1'b0;
    repeat (TOUT - 1) cycle();
    n_cmp++;
    if ({bif.grant, bif.bus_err} !== {8'h04, 1'b0}) begin
      n_fail++;
      $display("FAIL to_cleared: got grant=%h err=%b, want 04/0", bif.grant, bif.bus_err);
    end
    cycle();
    n_cmp++;
    if ({bif.grant, bif.bus_err} !== {8'h00, 1'b1}) begin
      n_fail++;
      $display("FAIL to_second_abort: got grant=%h err=%b, want 00/1", bif.grant, bif.bus_err);
    end
    bif.BUS_req = 1'b0;
    bif.DMA     = 8'h00;
    cycle();
    n_cmp++;
    if (bif.bus_err !== 1'b0) begin
      n_fail++;
      $display("FAIL to_pulse_width: got err=%b, want 0", bif.bus_err);
    end
  endtask
`else
  task automatic test_hung_slave();
    int bad;
    apply_reset();
    bif.DMA = 8'h04;
    cycle();
    bif.BUS_req   = 1'b1;
    bif.BUS_ready = 1'b0;
    bad = 0;
    repeat (2000) begin
      cycle();
      if (bif.grant !== 8'h04 || bif.bus_err !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL hung_hold: got %0d bad cycles, want 0", bad);
    end
    bif.BUS_req = 1'b0;
    bif.DMA     = 8'h00;
    cycle();
  endtask
`endif

  task automatic test_async_reset();
    apply_reset();
    bif.DMA = 8'h04;
    cycle();
    n_cmp++;
    if (bif.grant !== 8'h04) begin
      n_fail++;
      $display("FAIL ar_pre_grant: got grant=%h, want 04", bif.grant);
    end
    bif.BUS_req = 1'b1;
    #2;
    clr_in = 1'b0;
    #1;
    n_cmp++;
    if ({bif.grant, bif.bus_busy} !== {8'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL ar_async_drop: got grant=%h busy=%b, want 00/0", bif.grant, bif.bus_busy);
    end
    model_reset();
    @(negedge clk);
    bif.BUS_req = 1'b0;
    bif.DMA     = 8'h14;
    clr_in      = 1'b1;
    cycle();
    n_cmp++;
    if ({bif.grant, bif.owner} !== {8'h04, 3'd2}) begin
      n_fail++;
      $display("FAIL ar_ptr_restart: got grant=%h owner=%0d, want 04/2", bif.grant, bif.owner);
    end
    bif.DMA = 8'h00;
    cycle();
  endtask

  task automatic test_random();
    logic [7:0]  prev_grant;
    logic [15:0] act;
    logic [15:0] exp;
    apply_reset();
    prev_grant = 8'h00;
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 3) == 0) bif.DMA = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 9) == 0) bif.DMA = 8'h00;
      bif.BUS_req   = ($urandom_range(0, 3) != 0);
      bif.BUS_ready = ($urandom_range(0, 2) == 0);
      cycle();
      act = {bif.grant, bif.bus_busy, bif.owner, bif.bus_err, bif.err_master};
      exp = {exp_grant(), (m_owner >= 0), 3'(m_last), m_err, 3'(m_err_master)};
      n_cmp++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL rand_cycle %0d: got {grant,busy,owner,err,errm}=%h, want %h", n, act, exp);
      end
      n_cmp++;
      if ($countones(bif.grant) > 1 ||
          (prev_grant != 8'h00 && bif.grant != 8'h00 && bif.grant != prev_grant)) begin
        n_fail++;
        $display("FAIL rand_grant_shape %0d: got grant=%h after %h, want one-hot via idle", n, bif.grant, prev_grant);
      end
      prev_grant = bif.grant;
    end
  endtask

  initial begin
    clr_in        = 1'b0;
    bif.DMA       = 8'h00;
    bif.BUS_req   = 1'b0;
    bif.BUS_ready = 1'b0;
    test_reset();
    test_single_grant();
    test_rotation();
    test_quota();
`ifdef BUS_TIMEOUT_EN
    test_timeout();
    test_timeout_ready();
`else
    test_hung_slave();
`endif
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
